ioq_port_forwarder: RTL and testbench
=====================================

Name: ioq_port_forwarder

Overview:
- Parametrised packet forwarder on the user data path, between the input arbiter and the output port lookup / output queues.
- Buffers each packet in an input FIFO, then rewrites the IOQ module header destination field from the source port according to a run-time mode.
- Drops malformed packets and packets from invalid sources, and keeps forwarded and dropped packet counters.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- NUM_MAC_PORTS, 4, number of MAC ports. MAC port i is one-hot bit 2i of the 16-bit port field. Legal values are 2, 4, 6, 8.
- FIFO_DEPTH_BITS, 3, log2 of the input FIFO depth.
- CNT_WIDTH, 32, width of the packet counters.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-low reset.
- in_data  in  DATA_WIDTH  upstream data.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl.
- in_wr  in  1  upstream word valid.
- in_rdy  out  1  upstream may write.
- out_data  out  DATA_WIDTH  downstream data, registered.
- out_ctrl  out  CTRL_WIDTH  downstream ctrl, registered.
- out_wr  out  1  downstream word valid, registered.
- out_rdy  in  1  downstream may accept.
- cfg_mode  in  2  0 pass, 1 pair-swap, 2 flood, 3 loopback.
- cnt_clr  in  1  synchronous clear of both counters.
- pkt_fwd_cnt  out  CNT_WIDTH  packets forwarded.
- pkt_drop_cnt  out  CNT_WIDTH  packets dropped.

Behaviour:
- Reset (reset=0, asynchronous): FSM goes to IDLE, FIFO is emptied, and out_wr=0, out_data=0, out_ctrl=0, both counters=0.
  - A reset in mid-packet discards the partial packet.
  - After reset release, input is accepted as soon as in_rdy=1.
- in_rdy = !fifo_nearly_full.
  - Words written while in_rdy=0 (up to the nearly-full margin) must still be stored.
- Packet framing:
  - Word 0 is the IOQ header: ctrl == IOQ_CTRL (8'hFF). Source field is [IOQ_SRC_PORT_POS+15:IOQ_SRC_PORT_POS]; destination field is [IOQ_DST_PORT_POS+15:IOQ_DST_PORT_POS].
  - Any further module-header words (ctrl != 0) follow the IOQ header, then data words (ctrl == 0).
  - End of packet is the first word with ctrl != 0 that follows at least one ctrl == 0 word.
- FSM states: IDLE, HDR, BODY, DROP.
  - IDLE: when the FIFO is not empty, evaluate the head word. The head is never popped in IDLE.
    - Head ctrl != IOQ_CTRL, or the source field is not exactly one bit at an even position below 2*NUM_MAC_PORTS: go to DROP.
    - Otherwise latch cfg_mode and go to HDR.
  - HDR: when out_rdy && !empty, pop the IOQ header and emit it with dst rewritten, then go to BODY. The dst rewrite by latched mode is:
    - mode 0: dst unchanged.
    - mode 1: port index k maps to k^1.
    - mode 2: all MAC port bits set except the source bit; CPU bits cleared.
    - mode 3: dst = src.
    - All other header bits pass unchanged.
  - BODY: when out_rdy && !empty, pop and emit the word unmodified. At end of packet, return to IDLE and increment pkt_fwd_cnt.
  - DROP: when !empty, pop the word regardless of out_rdy; out_wr stays 0. At end of packet, return to IDLE and increment pkt_drop_cnt.
- Mode handling:
  - cfg_mode is sampled once per packet, in IDLE.
  - Changes to cfg_mode in mid-packet have no effect on the current packet.
- Output:
  - out_wr is asserted only in a cycle after out_rdy=1 was seen with a pop; it is never asserted while the FIFO is empty.
  - When out_wr=0, out_data and out_ctrl hold their previous values.
- Latency: a word written at cycle N appears on out_* at cycle N+2 at the earliest (fallthrough FIFO plus output register), plus 1 cycle for the IDLE evaluation on a packet's first word.
- Throughput: one word per cycle within a packet. There is one idle cycle between packets, in IDLE.
- Counters:
  - Both counters wrap modulo 2^CNT_WIDTH.
  - If cnt_clr and an increment occur in the same cycle, clear wins and the counter reads 0.

Decomposition:
- Shared defines file holds:
  - IOQ_CTRL (8'hFF).
  - IOQ_SRC_PORT_POS (16) and IOQ_DST_PORT_POS (48).
  - The mode encodings MODE_PASS, MODE_SWAP, MODE_FLOOD, MODE_LOOP.
- Reuse the existing fallthrough_small_fifo (WIDTH=CTRL_WIDTH+DATA_WIDTH, MAX_DEPTH_BITS=FIFO_DEPTH_BITS) with its reset tied to !reset.
- Add one new sub-module, ioq_dst_rewrite: combinational; inputs src, mode, NUM_MAC_PORTS; outputs new dst and src_valid.

Test Plan:
- mode=1, 4 ports, src=0x0004, 4-word packet (header, 2 data, EOP ctrl=0x01) -> out header dst=0x0001, other words bit-exact, pkt_fwd_cnt=1.
- mode=2, src=0x0010 -> dst=0x0045; mode=3, src=0x0040 -> dst=0x0040; mode=0 -> dst unchanged.
- src=0x0002 (CPU port), and separately a first word with ctrl=0x01 -> no out_wr for either packet; pkt_drop_cnt=2; a following valid packet is forwarded.
- out_rdy held low 20 cycles while 12 words are offered -> in_rdy drops, no word is lost or duplicated, order preserved after release; cfg_mode changed mid-packet does not alter that packet's dst.
- reset pulsed low in the middle of BODY -> out_wr=0 and counters=0 immediately; the next packet is forwarded intact. cnt_clr coincident with end of packet -> counter reads 0.

Source files
------------

// File: rtl/ioq_port_forwarder_pkg.sv
// Shared IOQ header constants and type definitions for the port forwarder.
package ioq_port_forwarder_pkg;

  localparam logic [7:0]  IOQ_CTRL         = 8'hFF;
  localparam int unsigned IOQ_SRC_PORT_POS = 16;
  localparam int unsigned IOQ_DST_PORT_POS = 48;
  localparam int unsigned PORT_W           = 16;

  typedef enum logic [1:0] {
    MODE_PASS  = 2'd0,
    MODE_SWAP  = 2'd1,
    MODE_FLOOD = 2'd2,
    MODE_LOOP  = 2'd3
  } fwd_mode_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_BODY = 2'd2,
    ST_DROP = 2'd3
  } fwd_state_e;

endpackage

// File: rtl/fallthrough_small_fifo.sv
// Small first-word-fallthrough FIFO: the head entry is visible on dout while not empty.
module fallthrough_small_fifo #(
  parameter int unsigned WIDTH          = 72,
  parameter int unsigned MAX_DEPTH_BITS = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             empty
);

  localparam int unsigned MAX_DEPTH = 1 << MAX_DEPTH_BITS;
  localparam int unsigned PTR_W     = MAX_DEPTH_BITS;
  localparam int unsigned CNT_W     = MAX_DEPTH_BITS + 1;

  logic [WIDTH-1:0] r_mem [MAX_DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_depth;
  logic             w_do_wr;
  logic             w_do_rd;

  assign w_do_wr     = wr_en && !full;
  assign w_do_rd     = rd_en && !empty;
  assign dout        = r_mem[r_rd_ptr];
  assign empty       = (r_depth == '0);
  assign full        = (r_depth == CNT_W'(MAX_DEPTH));
  assign nearly_full = (r_depth >= CNT_W'(MAX_DEPTH - 1));

  // Storage array, written on accepted pushes only.
  always_ff @(posedge clk) begin
    if (w_do_wr) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointer and occupancy tracking; reset empties the queue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_depth  <= '0;
    end else begin
      if (w_do_wr) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_rd) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_wr, w_do_rd})
        2'b10:   r_depth <= r_depth + CNT_W'(1);
        2'b01:   r_depth <= r_depth - CNT_W'(1);
        default: r_depth <= r_depth;
      endcase
    end
  end

endmodule

// File: rtl/ioq_dst_rewrite.sv
// Combinational destination rewrite from a one-hot MAC source port and a forwarding mode.
module ioq_dst_rewrite
  import ioq_port_forwarder_pkg::*;
#(
  parameter int unsigned NUM_MAC_PORTS = 4
) (
  input  logic [PORT_W-1:0] i_src,
  input  logic [PORT_W-1:0] i_dst,
  input  logic [1:0]        i_mode,
  output logic [PORT_W-1:0] o_dst,
  output logic              o_src_valid
);

  logic [PORT_W-1:0] w_mac_mask;
  logic [PORT_W-1:0] w_swap_dst;

  // Decode the source port index, build the MAC mask and the pair-swapped port.
  always_comb begin
    w_mac_mask  = '0;
    w_swap_dst  = '0;
    o_src_valid = 1'b0;
    for (int unsigned i = 0; i < NUM_MAC_PORTS; i++) begin
      w_mac_mask = w_mac_mask | (PORT_W'(1) << (2 * i));
      if (i_src == (PORT_W'(1) << (2 * i))) begin
        o_src_valid = 1'b1;
        w_swap_dst  = PORT_W'(1) << (2 * (i ^ 1));
      end
    end
  end

  // Select the new destination field by mode.
  always_comb begin
    o_dst = i_dst;
    case (i_mode)
      MODE_PASS:  o_dst = i_dst;
      MODE_SWAP:  o_dst = w_swap_dst;
      MODE_FLOOD: o_dst = w_mac_mask & ~i_src;
      MODE_LOOP:  o_dst = i_src;
      default:    o_dst = i_dst;
    endcase
  end

endmodule

// File: rtl/ioq_port_forwarder.sv
// IOQ packet forwarder: buffers packets, rewrites the header destination, drops bad packets.
module ioq_port_forwarder
  import ioq_port_forwarder_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int unsigned NUM_MAC_PORTS   = 4,
  parameter int unsigned FIFO_DEPTH_BITS = 3,
  parameter int unsigned CNT_WIDTH       = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  input  logic [1:0]            cfg_mode,
  input  logic                  cnt_clr,
  output logic [CNT_WIDTH-1:0]  pkt_fwd_cnt,
  output logic [CNT_WIDTH-1:0]  pkt_drop_cnt
);

  localparam int unsigned FIFO_W = CTRL_WIDTH + DATA_WIDTH;

  fwd_state_e            r_state;
  fwd_mode_e             r_mode;
  logic                  r_seen_data;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [CTRL_WIDTH-1:0] r_out_ctrl;
  logic                  r_out_wr;
  logic [CNT_WIDTH-1:0]  r_fwd_cnt;
  logic [CNT_WIDTH-1:0]  r_drop_cnt;

  logic [FIFO_W-1:0]     w_fifo_dout;
  logic [DATA_WIDTH-1:0] w_head_data;
  logic [CTRL_WIDTH-1:0] w_head_ctrl;
  logic                  w_empty;
  logic                  w_full;
  logic                  w_nearly_full;
  logic                  w_fifo_wr;
  logic                  w_pop;
  logic                  w_head_eop;
  logic                  w_head_is_ioq;
  logic                  w_src_valid;
  logic [PORT_W-1:0]     w_new_dst;
  logic [DATA_WIDTH-1:0] w_hdr_data;
  logic                  w_fwd_inc;
  logic                  w_drop_inc;

  assign w_fifo_wr = in_wr && !w_full;

  fallthrough_small_fifo #(
    .WIDTH          (FIFO_W),
    .MAX_DEPTH_BITS (FIFO_DEPTH_BITS)
  ) u_in_fifo (
    .clk         (clk),
    .reset       (!reset),
    .din         ({in_ctrl, in_data}),
    .wr_en       (w_fifo_wr),
    .rd_en       (w_pop),
    .dout        (w_fifo_dout),
    .full        (w_full),
    .nearly_full (w_nearly_full),
    .empty       (w_empty)
  );

  assign {w_head_ctrl, w_head_data} = w_fifo_dout;

  ioq_dst_rewrite #(
    .NUM_MAC_PORTS (NUM_MAC_PORTS)
  ) u_dst_rewrite (
    .i_src       (w_head_data[IOQ_SRC_PORT_POS +: PORT_W]),
    .i_dst       (w_head_data[IOQ_DST_PORT_POS +: PORT_W]),
    .i_mode      (r_mode),
    .o_dst       (w_new_dst),
    .o_src_valid (w_src_valid)
  );

  assign in_rdy        = !w_nearly_full;
  assign w_head_is_ioq = (w_head_ctrl == CTRL_WIDTH'(IOQ_CTRL));
  assign w_head_eop    = (w_head_ctrl != '0) && r_seen_data;
  assign w_fwd_inc     = (r_state == ST_BODY) && w_pop && w_head_eop;
  assign w_drop_inc    = (r_state == ST_DROP) && w_pop && w_head_eop;

  // Header word with only the destination field replaced.
  always_comb begin
    w_hdr_data = w_head_data;
    w_hdr_data[IOQ_DST_PORT_POS +: PORT_W] = w_new_dst;
  end

  // Pop the head when the current state can consume it; drops ignore backpressure.
  always_comb begin
    w_pop = 1'b0;
    case (r_state)
      ST_HDR, ST_BODY: w_pop = out_rdy && !w_empty;
      ST_DROP:         w_pop = !w_empty;
      default:         w_pop = 1'b0;
    endcase
  end

  // Packet FSM with registered output word and packet counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_mode      <= MODE_PASS;
      r_seen_data <= 1'b0;
      r_out_data  <= '0;
      r_out_ctrl  <= '0;
      r_out_wr    <= 1'b0;
      r_fwd_cnt   <= '0;
      r_drop_cnt  <= '0;
    end else begin
      r_out_wr <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_seen_data <= 1'b0;
          if (!w_empty) begin
            if (w_head_is_ioq && w_src_valid) begin
              r_mode  <= fwd_mode_e'(cfg_mode);
              r_state <= ST_HDR;
            end else begin
              r_state <= ST_DROP;
            end
          end
        end
        ST_HDR: begin
          if (w_pop) begin
            r_out_wr   <= 1'b1;
            r_out_data <= w_hdr_data;
            r_out_ctrl <= w_head_ctrl;
            r_state    <= ST_BODY;
          end
        end
        ST_BODY: begin
          if (w_pop) begin
            r_out_wr   <= 1'b1;
            r_out_data <= w_head_data;
            r_out_ctrl <= w_head_ctrl;
            if (w_head_eop) begin
              r_state     <= ST_IDLE;
              r_seen_data <= 1'b0;
            end else if (w_head_ctrl == '0) begin
              r_seen_data <= 1'b1;
            end
          end
        end
        ST_DROP: begin
          if (w_pop) begin
            if (w_head_eop) begin
              r_state     <= ST_IDLE;
              r_seen_data <= 1'b0;
            end else if (w_head_ctrl == '0) begin
              r_seen_data <= 1'b1;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (cnt_clr) begin
        r_fwd_cnt <= '0;
      end else if (w_fwd_inc) begin
        r_fwd_cnt <= r_fwd_cnt + CNT_WIDTH'(1);
      end

      if (cnt_clr) begin
        r_drop_cnt <= '0;
      end else if (w_drop_inc) begin
        r_drop_cnt <= r_drop_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign out_data     = r_out_data;
  assign out_ctrl     = r_out_ctrl;
  assign out_wr       = r_out_wr;
  assign pkt_fwd_cnt  = r_fwd_cnt;
  assign pkt_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_ioq_port_forwarder.sv
// Directed bench for ioq_port_forwarder: rewrite modes, drops, backpressure, reset, counter clear.
module tb_ioq_port_forwarder;

  typedef logic [71:0] word_t;
  typedef word_t wq_t[$];

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] in_data;
  logic [7:0]  in_ctrl;
  logic        in_wr;
  logic        in_rdy;
  logic [63:0] out_data;
  logic [7:0]  out_ctrl;
  logic        out_wr;
  logic        out_rdy;
  logic [1:0]  cfg_mode;
  logic        cnt_clr;
  logic [31:0] pkt_fwd_cnt;
  logic [31:0] pkt_drop_cnt;

  int    n_cmp = 0;
  int    n_bad = 0;
  int    exp_fwd = 0;
  int    exp_drop = 0;
  word_t rxq[$];

  always #5 clk = ~clk;

  ioq_port_forwarder dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_ctrl      (in_ctrl),
    .in_wr        (in_wr),
    .in_rdy       (in_rdy),
    .out_data     (out_data),
    .out_ctrl     (out_ctrl),
    .out_wr       (out_wr),
    .out_rdy      (out_rdy),
    .cfg_mode     (cfg_mode),
    .cnt_clr      (cnt_clr),
    .pkt_fwd_cnt  (pkt_fwd_cnt),
    .pkt_drop_cnt (pkt_drop_cnt)
  );

  // Collect every emitted output word.
  always @(negedge clk) begin
    if (reset && out_wr) rxq.push_back({out_ctrl, out_data});
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input word_t obs, input word_t exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic word_t hdr(input logic [15:0] dst, input logic [15:0] src);
    return {8'hFF, dst, 16'hBEEF, src, 16'hC0DE};
  endfunction

  function automatic wq_t mk_pkt(input logic [15:0] dst, input logic [15:0] src,
                                 input int ndata, input logic [15:0] seed);
    wq_t q;
    q.push_back(hdr(dst, src));
    for (int i = 0; i < ndata; i++) q.push_back({8'h00, seed, 16'h0000, 32'(i)});
    q.push_back({8'h01, seed, 48'hE0F0_0000_0000});
    return q;
  endfunction

  task automatic send(input wq_t p);
    for (int i = 0; i < p.size(); i++) begin
      int t = 0;
      @(negedge clk);
      while (!in_rdy && t < 300) begin
        in_wr = 1'b0;
        @(negedge clk);
        t++;
      end
      if (!in_rdy) begin
        check("send_in_rdy_timeout", 72'(in_rdy), 72'(1));
        in_wr = 1'b0;
        return;
      end
      in_wr = 1'b1;
      {in_ctrl, in_data} = p[i];
    end
    @(negedge clk);
    in_wr = 1'b0;
  endtask

  task automatic expect_pkt(input string tag, input wq_t e);
    int t = 0;
    while (rxq.size() < e.size() && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (rxq.size() < e.size()) begin
      check({tag, "_timeout"}, 72'(rxq.size()), 72'(e.size()));
      rxq.delete();
      return;
    end
    for (int i = 0; i < e.size(); i++) check($sformatf("%s_w%0d", tag, i), rxq.pop_front(), e[i]);
  endtask

  task automatic fwd_pkt(input string tag, input logic [1:0] mode, input logic [15:0] dst,
                         input logic [15:0] src, input logic [15:0] new_dst, input int ndata,
                         input logic [15:0] seed);
    wq_t p;
    wq_t e;
    cfg_mode = mode;
    p = mk_pkt(dst, src, ndata, seed);
    e = p;
    e[0] = hdr(new_dst, src);
    send(p);
    expect_pkt(tag, e);
    exp_fwd++;
    check({tag, "_fwd_cnt"}, 72'(pkt_fwd_cnt), 72'(exp_fwd));
  endtask

  initial begin
    wq_t p;
    wq_t e;
    reset    = 1'b0;
    in_wr    = 1'b0;
    in_data  = '0;
    in_ctrl  = '0;
    out_rdy  = 1'b1;
    cfg_mode = 2'd0;
    cnt_clr  = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_out_wr", 72'(out_wr), 72'(0));
    check("rst_out_data", 72'(out_data), 72'(0));
    check("rst_out_ctrl", 72'(out_ctrl), 72'(0));
    check("rst_fwd_cnt", 72'(pkt_fwd_cnt), 72'(0));
    check("rst_drop_cnt", 72'(pkt_drop_cnt), 72'(0));
    reset = 1'b1;
    @(negedge clk);
    check("rst_in_rdy", 72'(in_rdy), 72'(1));

    // Rewrite modes on a 4-port build.
    fwd_pkt("swap",  2'd1, 16'h0100, 16'h0004, 16'h0001, 2, 16'hA001);
    fwd_pkt("flood", 2'd2, 16'h0000, 16'h0010, 16'h0045, 3, 16'hA002);
    fwd_pkt("loop",  2'd3, 16'h0003, 16'h0040, 16'h0040, 1, 16'hA003);
    fwd_pkt("pass",  2'd0, 16'h1234, 16'h0001, 16'h1234, 2, 16'hA004);

    // CPU source, out-of-range source and a non-IOQ first word are all dropped.
    cfg_mode = 2'd0;
    send(mk_pkt(16'h0001, 16'h0002, 2, 16'hB001));
    send(mk_pkt(16'h0001, 16'h0100, 1, 16'hB002));
    p.delete();
    p.push_back({8'h01, 64'h0000_0000_0000_00AA});
    p.push_back({8'h00, 64'h0000_0000_0000_00BB});
    p.push_back({8'h00, 64'h0000_0000_0000_00CC});
    p.push_back({8'h01, 64'h0000_0000_0000_00DD});
    send(p);
    repeat (20) @(negedge clk);
    exp_drop = 3;
    check("drop_no_out", 72'(rxq.size()), 72'(0));
    check("drop_cnt", 72'(pkt_drop_cnt), 72'(exp_drop));
    check("drop_fwd_cnt", 72'(pkt_fwd_cnt), 72'(exp_fwd));
    fwd_pkt("post_drop", 2'd0, 16'h0004, 16'h0040, 16'h0004, 2, 16'hA005);

    // Backpressure with a 12-word packet and a mid-packet mode change.
    out_rdy  = 1'b0;
    cfg_mode = 2'd1;
    p = mk_pkt(16'h0000, 16'h0001, 10, 16'hC001);
    e = p;
    e[0] = hdr(16'h0004, 16'h0001);
    fork
      send(p);
      begin
        repeat (5) @(negedge clk);
        cfg_mode = 2'd3;
        repeat (15) @(negedge clk);
        check("bp_in_rdy_low", 72'(in_rdy), 72'(0));
        check("bp_no_out", 72'(rxq.size()), 72'(0));
        out_rdy = 1'b1;
      end
    join
    expect_pkt("bp", e);
    exp_fwd++;
    check("bp_fwd_cnt", 72'(pkt_fwd_cnt), 72'(exp_fwd));
    cfg_mode = 2'd0;

    // Asynchronous reset while a packet is in BODY.
    out_rdy = 1'b0;
    send(mk_pkt(16'h0011, 16'h0004, 3, 16'hD001));
    repeat (3) @(negedge clk);
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_rdy = 1'b0;
    check("mid_out_wr", 72'(out_wr), 72'(1));
    #1 reset = 1'b0;
    #1;
    check("mid_rst_out_wr", 72'(out_wr), 72'(0));
    check("mid_rst_out_data", 72'(out_data), 72'(0));
    check("mid_rst_fwd_cnt", 72'(pkt_fwd_cnt), 72'(0));
    check("mid_rst_drop_cnt", 72'(pkt_drop_cnt), 72'(0));
    @(negedge clk);
    reset = 1'b1;
    rxq.delete();
    exp_fwd  = 0;
    exp_drop = 0;
    @(negedge clk);
    check("mid_rst_in_rdy", 72'(in_rdy), 72'(1));
    out_rdy = 1'b1;
    fwd_pkt("post_rst", 2'd1, 16'h0000, 16'h0040, 16'h0010, 2, 16'hA006);
    repeat (5) @(negedge clk);
    check("post_rst_no_extra", 72'(rxq.size()), 72'(0));

    // Counter clear in the same cycle as the end-of-packet pop.
    out_rdy  = 1'b0;
    cfg_mode = 2'd0;
    p = mk_pkt(16'h0055, 16'h0001, 1, 16'hE001);
    send(p);
    repeat (3) @(negedge clk);
    check("clr_pre_fwd_cnt", 72'(pkt_fwd_cnt), 72'(1));
    out_rdy = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    check("clr_fwd_cnt", 72'(pkt_fwd_cnt), 72'(0));
    check("clr_drop_cnt", 72'(pkt_drop_cnt), 72'(0));
    expect_pkt("clr", p);
    repeat (3) @(negedge clk);
    check("clr_fwd_cnt_hold", 72'(pkt_fwd_cnt), 72'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
